outr_uart_tx: RTL and testbench
===============================

OUTR_UART_TX -- requirements
Module: outr_uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port ld_outr  input  1  one-cycle strobe: CPU loads OUTR.
REQ-005 The block SHALL have port outr  input  16  output-register word, sampled when ld_outr is accepted.
REQ-006 The block SHALL have port ien  input  1  output-interrupt enable.
REQ-007 The block SHALL have port clr_ovr  input  1  clears the overrun flag.
REQ-008 The block SHALL have port tx  output  1  serial line, idle high.
REQ-009 The block SHALL have port fgo  output  1  output flag: 1 = ready for a new word.
REQ-010 The block SHALL have port irq  output  1  equals ien AND fgo.
REQ-011 The block SHALL have port ovr  output  1  sticky overrun flag.

Function
REQ-012 ld_outr SHALL be accepted only when fgo=1; on that edge outr SHALL be captured into an internal 16-bit holding register and fgo SHALL be 0 from the next cycle.
REQ-013 The word SHALL be sent as two 8N1 frames, low byte first, then high byte; each frame is start bit (0), 8 data bits LSB first, stop bit (1).
REQ-014 Each bit SHALL last exactly CLK_DIV cycles, timed by a bit counter that reloads at every bit boundary.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP; IDLE->START on accept; START->DATA after CLK_DIV cycles; DATA->STOP after 8 bits; STOP->START if the low byte was just sent, else STOP->IDLE.
REQ-016 tx SHALL be driven low in the first cycle after acceptance; the whole word SHALL take exactly 20*CLK_DIV cycles, with no idle gap between the frames.
REQ-017 fgo SHALL return to 1 in the cycle after the last stop-bit cycle; a new ld_outr in that cycle SHALL be accepted, giving back-to-back words.
REQ-018 ld_outr while fgo=0 SHALL be ignored (the holding register and the transfer are unaffected) and SHALL set ovr=1.
REQ-019 ovr SHALL clear on clr_ovr=1; if clr_ovr and an overrunning ld_outr occur in the same cycle, ovr SHALL end up 1 (set wins).
REQ-020 tx SHALL be registered (glitch-free); in IDLE it SHALL be 1.
REQ-021 irq SHALL be combinational from ien and fgo, with no extra latency.

Reset
REQ-022 While reset=0: tx=1, fgo=1, ovr=0, irq=ien, FSM=IDLE, counters and the holding register = 0.
REQ-023 Assertion mid-frame SHALL abort the transfer immediately (asynchronously); after release no partial frame SHALL resume.
REQ-024 The first ld_outr SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-025 The FSM state encoding and the frame constants (8 data bits, 2 bytes per word, 10 bits per frame) SHALL live in the shared CPU package.
REQ-026 One sub-module, baud_tick, SHALL hold the CLK_DIV down-counter and emit a bit-boundary pulse; everything else SHALL be in outr_uart_tx.

Verification (CLK_DIV=4)
REQ-027 Reset release, then ld_outr with outr=16'hA55A -> tx low bits: 0, then 01011010 (LSB first), then 1; then 0, 10100101, 1; each level held 4 cycles; fgo=1 again at cycle 81.
REQ-028 Second ld_outr with 16'h1234, issued 10 cycles into a transfer -> ovr=1, serial stream still A55A; then clr_ovr -> ovr=0.
REQ-029 ld_outr with 16'h00FF on the fgo-rising cycle, straight after a previous word -> start bit in the next cycle, no idle gap.
REQ-030 reset pulsed low at cycle 30 of a transfer -> tx=1 and fgo=1 immediately; no further low bits until a new ld_outr.
REQ-031 ien=1 during a transfer -> irq=0 until fgo rises; ien=0 -> irq=0 always.
REQ-032 Same cycle clr_ovr=1 and an overrunning ld_outr -> ovr=1.

Source files
------------

// File: rtl/outr_uart_tx_pkg.sv
// Shared definitions for the OUTR serial transmitter: FSM encoding and frame geometry.
package outr_uart_tx_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 2;
    localparam int BITS_PER_FRAME = 1 + DATA_BITS + 1;

    // Clock cycles needed to shift out one full 16-bit word.
    function automatic int word_cycles(input int clk_div);
        return BITS_PER_FRAME * BYTES_PER_WORD * clk_div;
    endfunction

endpackage

// File: rtl/outr_uart_tx_if.sv
// CPU-side handshake and status bundle of the OUTR serial transmitter.
interface outr_uart_tx_if;

    logic        ld_outr;
    logic [15:0] outr;
    logic        ien;
    logic        clr_ovr;
    logic        tx;
    logic        fgo;
    logic        irq;
    logic        ovr;

    modport master (
        output ld_outr, outr, ien, clr_ovr,
        input  tx, fgo, irq, ovr
    );

    modport slave (
        input  ld_outr, outr, ien, clr_ovr,
        output tx, fgo, irq, ovr
    );

endinterface

// File: rtl/outr_uart_tx_baud_tick.sv
// Bit-period timer: a CLK_DIV down-counter emitting one pulse per serial bit boundary.
module baud_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic tick
);

    localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

    logic [15:0] cnt;

    // load restarts the period on acceptance; run keeps it reloading at every boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (run) begin
            cnt <= (cnt == 16'd0) ? RELOAD : cnt - 16'd1;
        end
    end

    assign tick = run && (cnt == 16'd0);

endmodule

// File: rtl/outr_uart_tx.sv
// OUTR transmitter: sends a 16-bit word as two back-to-back 8N1 frames, low byte first.
module outr_uart_tx
    import outr_uart_tx_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic          clk,
    input  logic          reset,
    outr_uart_tx_if.slave bus
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_BYTE = 1'(BYTES_PER_WORD - 1);

    state_t      state;
    logic [15:0] hold;
    logic [2:0]  bit_idx;
    logic        byte_sel;
    logic        tx_q;
    logic        ovr_q;
    logic        fgo;
    logic        accept;
    logic        tick;
    logic [7:0]  cur_byte;
    logic [2:0]  next_idx;

    assign fgo      = (state == ST_IDLE);
    assign accept   = bus.ld_outr && fgo;
    assign cur_byte = byte_sel ? hold[15:8] : hold[7:0];
    assign next_idx = bit_idx + 3'd1;

    baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .run   (!fgo),
        .tick  (tick)
    );

    // tx is updated one edge ahead of each bit so the line itself stays a clean flop output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            hold     <= '0;
            bit_idx  <= '0;
            byte_sel <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        hold     <= bus.outr;
                        bit_idx  <= '0;
                        byte_sel <= 1'b0;
                        tx_q     <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        bit_idx <= '0;
                        tx_q    <= cur_byte[0];
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
                            tx_q  <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= next_idx;
                            tx_q    <= cur_byte[next_idx];
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (byte_sel == LAST_BYTE) begin
                            tx_q  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            byte_sel <= 1'b1;
                            tx_q     <= 1'b0;
                            state    <= ST_START;
                        end
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // An overrunning load takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr_q <= 1'b0;
        end else if (bus.ld_outr && !fgo) begin
            ovr_q <= 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_q <= 1'b0;
        end
    end

    assign bus.tx  = tx_q;
    assign bus.fgo = fgo;
    assign bus.irq = bus.ien && fgo;
    assign bus.ovr = ovr_q;

endmodule

// File: tb/tb_outr_uart_tx.sv
// Bench for outr_uart_tx: queue-based line model checked every cycle, plus directed literal checks.
module tb_outr_uart_tx;

    localparam int CLK_DIV = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    outr_uart_tx_if bus();

    outr_uart_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: every accepted word becomes a queue of line levels, one entry per clock cycle.
    bit   exp_q[$];
    logic m_tx  = 1'b1;
    logic m_fgo = 1'b1;
    logic m_ovr = 1'b0;

    task automatic push_word(input logic [15:0] w);
        logic [7:0] b;
        for (int k = 0; k < 2; k++) begin
            b = w[8*k +: 8];
            repeat (CLK_DIV) exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (CLK_DIV) exp_q.push_back(b[i]);
            repeat (CLK_DIV) exp_q.push_back(1'b1);
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            exp_q.delete();
            m_tx  = 1'b1;
            m_fgo = 1'b1;
            m_ovr = 1'b0;
        end else begin
            if (bus.ld_outr && m_fgo) push_word(bus.outr);
            if (bus.ld_outr && !m_fgo) m_ovr = 1'b1;
            else if (bus.clr_ovr) m_ovr = 1'b0;
            if (exp_q.size() > 0) begin
                m_tx  = exp_q.pop_front();
                m_fgo = 1'b0;
            end else begin
                m_tx  = 1'b1;
                m_fgo = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("tx",  bus.tx,  m_tx);
        check("fgo", bus.fgo, m_fgo);
        check("irq", bus.irq, bus.ien & m_fgo);
        check("ovr", bus.ovr, m_ovr);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int limit);
        bit found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            if (bus.fgo) found = 1'b1;
            else cyc();
        end
        if (!found) check("idle_timeout", 32'd0, 32'd1);
    endtask

    logic [19:0] frame_a55a;

    initial begin
        // Line levels of 16'hA55A, bit i = i-th bit period on tx.
        frame_a55a  = 20'hD2AB4;
        bus.ld_outr = 1'b0;
        bus.outr    = '0;
        bus.ien     = 1'b1;
        bus.clr_ovr = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx",  bus.tx,  1);
        check("rst_fgo", bus.fgo, 1);
        check("rst_ovr", bus.ovr, 0);
        check("rst_irq", bus.irq, 1);

        // Release reset and load in the same cycle: accepted on the very next edge.
        #1;
        reset       = 1'b1;
        bus.ld_outr = 1'b1;
        bus.outr    = 16'hA55A;
        cyc();
        bus.ld_outr = 1'b0;
        for (int c = 1; c <= 81; c++) begin
            if (c > 1) cyc();
            if (c <= 80 && ((c - 1) % CLK_DIV) == 1)
                check("a55a_bit", bus.tx, frame_a55a[(c - 1) / CLK_DIV]);
            if (c == 10) begin bus.ld_outr = 1'b1; bus.outr = 16'h1234; end
            if (c == 11) bus.ld_outr = 1'b0;
            if (c == 13) check("ovr_set", bus.ovr, 1);
            if (c == 40) check("irq_busy", bus.irq, 0);
            if (c == 80) check("fgo_busy", bus.fgo, 0);
            if (c == 81) begin
                check("fgo_back", bus.fgo, 1);
                check("irq_back", bus.irq, 1);
                bus.ld_outr = 1'b1;
                bus.outr    = 16'h00FF;
                bus.clr_ovr = 1'b1;
            end
        end

        cyc();
        bus.ld_outr = 1'b0;
        bus.clr_ovr = 1'b0;
        check("b2b_start", bus.tx,  0);
        check("b2b_fgo",   bus.fgo, 0);
        check("ovr_clr",   bus.ovr, 0);

        repeat (8) cyc();
        bus.ld_outr = 1'b1;
        bus.clr_ovr = 1'b1;
        cyc();
        bus.ld_outr = 1'b0;
        bus.clr_ovr = 1'b0;
        cyc();
        check("ovr_set_wins", bus.ovr, 1);
        bus.clr_ovr = 1'b1;
        cyc();
        bus.clr_ovr = 1'b0;
        cyc();
        check("ovr_clr2", bus.ovr, 0);

        bus.ien = 1'b0;
        wait_idle(200);
        repeat (3) cyc();
        check("irq_masked", bus.irq, 0);
        bus.ien = 1'b1;

        // Reset asserted between edges, 30 cycles into a word.
        bus.ld_outr = 1'b1;
        bus.outr    = 16'h0F0F;
        cyc();
        bus.ld_outr = 1'b0;
        repeat (29) cyc();
        check("pre_rst_tx", bus.tx, 0);
        reset = 1'b0;
        #1;
        check("async_rst_tx",  bus.tx,  1);
        check("async_rst_fgo", bus.fgo, 1);
        cyc();
        reset = 1'b1;
        repeat (100) cyc();
        check("no_resume_tx", bus.tx, 1);

        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 399) == 0) reset = 1'b0;
            bus.ld_outr = ($urandom_range(0, 7) == 0);
            bus.outr    = 16'($urandom);
            bus.clr_ovr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) bus.ien = ~bus.ien;
        end
        reset       = 1'b1;
        bus.ld_outr = 1'b0;
        bus.clr_ovr = 1'b0;
        wait_idle(200);
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
